reg_writeback_arbiter: RTL and testbench
========================================

Name: reg_writeback_arbiter

Overview:
- Writer-side partner of the 32x32 register file.
- Merges two result sources onto the single register-file write port (RegWrite / Write_addr / Write_data):
  - the single-cycle ALU path;
  - a long-latency completion path (multi-cycle load / mult-div), buffered in a small FIFO.
- Keeps a pending-register scoreboard so issue logic can stall on registers whose long-latency result has not yet been written.

Parameters:
- bit_size, 32, data width of results and of Write_data.
- FIFO_DEPTH, 4, number of buffered long-latency results; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- alu_we  input  1  ALU result valid this cycle.
- alu_addr  input  5  ALU destination register.
- alu_data  input  bit_size  ALU result.
- lt_valid  input  1  long-latency result offered.
- lt_ready  output  1  FIFO can accept; transfer when lt_valid && lt_ready.
- lt_addr  input  5  long-latency destination register.
- lt_data  input  bit_size  long-latency result.
- issue_lt  input  1  long-latency op issued this cycle; marks issue_addr pending.
- issue_addr  input  5  destination of the issued op.
- RegWrite  output  1  register-file write enable (registered).
- Write_addr  output  5  register-file write address (registered).
- Write_data  output  bit_size  register-file write data (registered).
- pending_mask  output  32  bit r = 1 while register r awaits a long-latency writeback.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  buffered entries.
- err  output  1  sticky protocol error flag.

Behaviour:
- Reset (async): FIFO empty, fifo_count=0, RegWrite=0, Write_addr=0, Write_data=0, pending_mask=0, err=0. lt_ready=1 once rst deasserts.
- Reset mid-operation discards all buffered results and pending bits. No write is issued in the cycle rst is high.
- lt_ready = (fifo_count != FIFO_DEPTH); purely combinational from count.
- Selection each cycle, registered to the outputs on the next edge (latency 1):
  - alu_we && alu_addr!=0 → drive ALU result.
  - else FIFO non-empty → pop the head entry and drive it.
  - else RegWrite=0; Write_addr and Write_data hold their previous values.
- ALU has strict priority. The FIFO drains only in cycles without a valid ALU write.
- alu_we with alu_addr=0 is treated as no ALU write, so the FIFO may drain that cycle. RegWrite is never asserted with Write_addr=0.
- Accepted lt transfer with lt_addr=0: consumed (handshake completes), not enqueued, no write issued.
- Push and pop in the same cycle: count unchanged. A push into a full FIFO is impossible by the handshake.
- FIFO order is strictly first-in first-out. Pointers wrap modulo FIFO_DEPTH.
- Bypass: an lt transfer into an empty FIFO with no ALU write is still enqueued first. Its earliest write is 2 edges after acceptance (no combinational bypass).
- Scoreboard:
  - issue_lt && issue_addr!=0 sets pending_mask[issue_addr].
  - A pending bit clears on the edge where RegWrite is registered with that Write_addr from the FIFO path.
  - Set and clear of the same bit in one cycle → set wins.
  - pending_mask[0] is always 0.
- err (sticky until reset) sets on either:
  - issue_lt to an already-pending register that is not being cleared this cycle (WAW);
  - a valid ALU write to a register whose pending bit is set (issue logic failed to stall).
  - The write itself still proceeds.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_ADDR_W=5, NUM_REGS=32, REG_ZERO=5'd0;
  - typedef wb_entry_t {addr[4:0], data[bit_size-1:0]}.
- One sub-module, wb_fifo: synchronous FIFO of wb_entry_t with push/pop/count, async reset, FIFO_DEPTH parameter.
- Arbitration, output registers and scoreboard stay in the top module.

Test Plan:
- ALU only: alu_we=1, alu_addr=8, alu_data=0x1234 for one cycle → next cycle RegWrite=1, Write_addr=8, Write_data=0x1234; following cycle RegWrite=0.
- Priority and order:
  - Stimulus: push lt results (9,0xAAAA) then (10,0xBBBB); hold alu_we=1 (addr 11) for 3 cycles.
  - Required: 3 ALU writes to reg 11 first, then reg 9, then reg 10 on consecutive cycles; fifo_count goes 2→1→0.
- Full FIFO: hold alu_we=1 and push 4 lt results → lt_ready=0 when fifo_count=4. A 5th lt_valid is not accepted. Dropping alu_we drains in FIFO order.
- Scoreboard:
  - issue_lt addr 12 → pending_mask[12]=1.
  - lt result for 12 written → bit clears on the same edge RegWrite=1/Write_addr=12 appears.
  - Issue 12 again in that cycle → bit stays 1.
- Zero register: alu_we addr 0 and lt result addr 0 → RegWrite never 1, handshake completes, pending_mask[0]=0.
- Errors and reset:
  - Issue addr 5 twice → err=1.
  - Separately, ALU write to pending reg 7 → err=1, write still seen.
  - Assert rst mid-drain with fifo_count=3 → all outputs 0 immediately, no further writes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the writeback entry format.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Result width carried by buffered writeback entries; matches the datapath width.
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries for long-latency results.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  wb_entry_t        mem_q [FIFO_DEPTH];
  wb_entry_t        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

  // Next-state for storage, pointers and occupancy; pointers wrap naturally since depth is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register; reset empties the FIFO and discards any buffered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Merges ALU and buffered long-latency results onto the single register-file write port,
// and tracks registers still waiting on a long-latency writeback.
module reg_writeback_arbiter
  import cpu_pkg::*;
#(
  parameter int bit_size   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_we,
  input  logic [4:0]                  alu_addr,
  input  logic [bit_size-1:0]         alu_data,
  input  logic                        lt_valid,
  output logic                        lt_ready,
  input  logic [4:0]                  lt_addr,
  input  logic [bit_size-1:0]         lt_data,
  input  logic                        issue_lt,
  input  logic [4:0]                  issue_addr,
  output logic                        RegWrite,
  output logic [4:0]                  Write_addr,
  output logic [bit_size-1:0]         Write_data,
  output logic [31:0]                 pending_mask,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  reg_write_q, reg_write_d;
  logic [4:0]            write_addr_q, write_addr_d;
  logic [bit_size-1:0]   write_data_q, write_data_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic                  err_q, err_d;

  logic                  alu_valid;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  waw_hazard;
  logic                  alu_hazard;
  wb_entry_t             push_entry;
  wb_entry_t             head;

  // Register 0 is hardwired, so writes to it are dropped on both paths.
  assign alu_valid  = alu_we && (alu_addr != REG_ZERO);
  assign lt_ready   = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign fifo_push  = lt_valid && lt_ready && (lt_addr != REG_ZERO);
  assign fifo_pop   = !alu_valid && !fifo_empty;
  assign push_entry = '{addr: lt_addr, data: lt_data};

  wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (head),
    .count      (fifo_count),
    .empty      (fifo_empty)
  );

  // Pick the write source (ALU first, then FIFO head), update the scoreboard and the sticky error.
  always_comb begin
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (alu_valid) begin
      reg_write_d  = 1'b1;
      write_addr_d = alu_addr;
      write_data_d = alu_data;
    end else if (fifo_pop) begin
      reg_write_d  = 1'b1;
      write_addr_d = head.addr;
      write_data_d = head.data;
    end

    waw_hazard = issue_lt && (issue_addr != REG_ZERO) && pending_q[issue_addr]
                 && !(fifo_pop && (head.addr == issue_addr));
    alu_hazard = alu_valid && pending_q[alu_addr];
    err_d      = err_q || waw_hazard || alu_hazard;

    pending_d = pending_q;
    if (fifo_pop) begin
      pending_d[head.addr] = 1'b0;
    end
    if (issue_lt && (issue_addr != REG_ZERO)) begin
      pending_d[issue_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Registered write port, scoreboard and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      pending_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      pending_q    <= pending_d;
      err_q        <= err_d;
    end
  end

  assign RegWrite     = reg_write_q;
  assign Write_addr   = write_addr_q;
  assign Write_data   = write_data_q;
  assign pending_mask = pending_q;
  assign err          = err_q;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Self-checking bench for reg_writeback_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_reg_writeback_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_we;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        lt_valid;
  logic        lt_ready;
  logic [4:0]  lt_addr;
  logic [31:0] lt_data;
  logic        issue_lt;
  logic [4:0]  issue_addr;
  logic        RegWrite;
  logic [4:0]  Write_addr;
  logic [31:0] Write_data;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;
  logic        err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pend;
  logic        m_err;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  reg_writeback_arbiter #(
    .bit_size   (32),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_we       (alu_we),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .lt_valid     (lt_valid),
    .lt_ready     (lt_ready),
    .lt_addr      (lt_addr),
    .lt_data      (lt_data),
    .issue_lt     (issue_lt),
    .issue_addr   (issue_addr),
    .RegWrite     (RegWrite),
    .Write_addr   (Write_addr),
    .Write_data   (Write_data),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count),
    .err          (err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_pend  = '0;
    m_err   = 1'b0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".RegWrite"}, 32'(RegWrite), 32'(m_we));
    checkOutput({tag, ".Write_addr"}, 32'(Write_addr), 32'(m_waddr));
    checkOutput({tag, ".Write_data"}, Write_data, m_wdata);
    checkOutput({tag, ".pending"}, pending_mask, m_pend);
    checkOutput({tag, ".count"}, 32'(fifo_count), 32'(m_q.size()));
    checkOutput({tag, ".err"}, 32'(err), 32'(m_err));
  endtask

  // One clock of stimulus; the reference model predicts the registered results after the edge.
  task automatic applyStimulus(input string tag,
                               input logic awe, input logic [4:0] aaddr, input logic [31:0] adata,
                               input logic lv, input logic [4:0] laddr, input logic [31:0] ldata,
                               input logic iss, input logic [4:0] iaddr);
    ent_t e;
    bit   popped;
    bit   accepted;
    bit   alu_ok;
    alu_we     = awe;
    alu_addr   = aaddr;
    alu_data   = adata;
    lt_valid   = lv;
    lt_addr    = laddr;
    lt_data    = ldata;
    issue_lt   = iss;
    issue_addr = iaddr;
    #1;
    checkOutput({tag, ".lt_ready"}, 32'(lt_ready), 32'(m_q.size() != DEPTH));

    alu_ok   = awe && (aaddr != 0);
    accepted = lv && (m_q.size() < DEPTH);
    popped   = 0;
    e        = '{a: 5'd0, d: 32'd0};
    if (!alu_ok && m_q.size() > 0) begin
      e      = m_q.pop_front();
      popped = 1;
    end
    if (accepted && laddr != 0) m_q.push_back('{a: laddr, d: ldata});
    if (iss && iaddr != 0 && m_pend[iaddr] && !(popped && e.a == iaddr)) m_err = 1'b1;
    if (alu_ok && m_pend[aaddr]) m_err = 1'b1;
    if (popped) m_pend[e.a] = 1'b0;
    if (iss && iaddr != 0) m_pend[iaddr] = 1'b1;
    m_pend[0] = 1'b0;
    if (alu_ok) begin
      m_we = 1'b1; m_waddr = aaddr; m_wdata = adata;
    end else if (popped) begin
      m_we = 1'b1; m_waddr = e.a; m_wdata = e.d;
    end else begin
      m_we = 1'b0;
    end

    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
  endtask

  // Synchronous-looking reset sequence; outputs must clear as soon as rst rises.
  task automatic applyReset(input string tag);
    alu_we = 0; lt_valid = 0; issue_lt = 0;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll({tag, ".inrst"});
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, ".ready_after"}, 32'(lt_ready), 32'd1);
    checkAll({tag, ".after"});
  endtask

  initial begin
    logic [4:0]  a;
    logic [4:0]  ia;
    logic [4:0]  la;

    rst = 1'b1;
    alu_we = 0; alu_addr = 0; alu_data = 0;
    lt_valid = 0; lt_addr = 0; lt_data = 0;
    issue_lt = 0; issue_addr = 0;
    modelReset();
    @(posedge clk);
    #1;
    applyReset("reset");

    // ALU-only write and its one-cycle pulse.
    applyStimulus("alu", 1, 5'd8, 32'h1234, 0, 5'd0, 32'd0, 0, 5'd0);
    checkOutput("alu.we_const", 32'(RegWrite), 32'd1);
    checkOutput("alu.addr_const", 32'(Write_addr), 32'd8);
    checkOutput("alu.data_const", Write_data, 32'h1234);
    idle("alu_idle");
    checkOutput("alu.we_drop", 32'(RegWrite), 32'd0);

    // ALU priority over buffered results, then FIFO order.
    applyStimulus("prio1", 1, 5'd11, 32'h11, 1, 5'd9, 32'hAAAA, 0, 5'd0);
    applyStimulus("prio2", 1, 5'd11, 32'h12, 1, 5'd10, 32'hBBBB, 0, 5'd0);
    applyStimulus("prio3", 1, 5'd11, 32'h13, 0, 5'd0, 32'd0, 0, 5'd0);
    checkOutput("prio3.addr_const", 32'(Write_addr), 32'd11);
    checkOutput("prio3.count_const", 32'(fifo_count), 32'd2);
    idle("prio_drain1");
    checkOutput("prio_drain1.addr_const", 32'(Write_addr), 32'd9);
    checkOutput("prio_drain1.count_const", 32'(fifo_count), 32'd1);
    idle("prio_drain2");
    checkOutput("prio_drain2.addr_const", 32'(Write_addr), 32'd10);
    checkOutput("prio_drain2.data_const", Write_data, 32'hBBBB);
    checkOutput("prio_drain2.count_const", 32'(fifo_count), 32'd0);

    // Fill the FIFO behind a stream of ALU writes; a fifth offer must be refused.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus("fill", 1, 5'd20, 32'(i), 1, 5'(i), 32'hF000 + 32'(i), 0, 5'd0);
    end
    checkOutput("full.count_const", 32'(fifo_count), 32'd4);
    checkOutput("full.ready_const", 32'(lt_ready), 32'd0);
    applyStimulus("full_offer5", 1, 5'd20, 32'd5, 1, 5'd6, 32'hF006, 0, 5'd0);
    checkOutput("full_offer5.count_const", 32'(fifo_count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      idle("full_drain");
      checkOutput("full_drain.addr_const", 32'(Write_addr), 32'(i));
    end
    idle("full_empty");

    // Scoreboard set/clear, and set winning over a same-cycle clear.
    applyStimulus("sb_issue", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd12);
    checkOutput("sb_issue.bit12", 32'(pending_mask[12]), 32'd1);
    applyStimulus("sb_push", 0, 5'd0, 32'd0, 1, 5'd12, 32'hC0DE, 0, 5'd0);
    checkOutput("sb_push.no_bypass", 32'(RegWrite), 32'd0);
    idle("sb_clear");
    checkOutput("sb_clear.bit12", 32'(pending_mask[12]), 32'd0);
    checkOutput("sb_clear.addr_const", 32'(Write_addr), 32'd12);
    applyStimulus("sb_issue2", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd12);
    applyStimulus("sb_push2", 0, 5'd0, 32'd0, 1, 5'd12, 32'hC0DF, 0, 5'd0);
    applyStimulus("sb_setwins", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd12);
    checkOutput("sb_setwins.bit12", 32'(pending_mask[12]), 32'd1);
    checkOutput("sb_setwins.err", 32'(err), 32'd0);
    applyStimulus("sb_push3", 0, 5'd0, 32'd0, 1, 5'd12, 32'hC0E0, 0, 5'd0);
    idle("sb_clear3");

    // Register zero is never written and never pending.
    applyStimulus("zero", 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 1, 5'd0);
    checkOutput("zero.we_const", 32'(RegWrite), 32'd0);
    checkOutput("zero.count_const", 32'(fifo_count), 32'd0);
    checkOutput("zero.pend0", 32'(pending_mask[0]), 32'd0);
    idle("zero_idle");
    checkOutput("zero_idle.we_const", 32'(RegWrite), 32'd0);

    // Random traffic that respects issue stalls, so err must stay low.
    for (int n = 0; n < 300; n++) begin
      do a = 5'($urandom_range(0, 31)); while (m_pend[a]);
      do ia = 5'($urandom_range(1, 31)); while (m_pend[ia]);
      la = 5'($urandom_range(0, 31));
      applyStimulus("rand", 1'($urandom_range(0, 1)), a, $urandom,
                    1'($urandom_range(0, 1)), la, $urandom,
                    ($urandom_range(0, 3) == 0), ia);
    end
    for (int n = 0; n < 6; n++) idle("rand_drain");

    // WAW issue error.
    applyReset("reset_waw");
    applyStimulus("waw1", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd5);
    applyStimulus("waw2", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd5);
    checkOutput("waw.err_const", 32'(err), 32'd1);

    // ALU write to a pending register: error raised, write still happens.
    applyReset("reset_haz");
    applyStimulus("haz_issue", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7);
    applyStimulus("haz_alu", 1, 5'd7, 32'h77, 0, 5'd0, 32'd0, 0, 5'd0);
    checkOutput("haz.err_const", 32'(err), 32'd1);
    checkOutput("haz.we_const", 32'(RegWrite), 32'd1);
    checkOutput("haz.addr_const", 32'(Write_addr), 32'd7);

    // Asynchronous reset in the middle of a drain.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus("md_fill", 1, 5'd21, 32'd0, 1, 5'(i + 1), 32'hD000 + 32'(i), 0, 5'd0);
    end
    idle("md_pop");
    checkOutput("md.count3", 32'(fifo_count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll("md_async");
    checkOutput("md_async.count0", 32'(fifo_count), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("md_inrst.we", 32'(RegWrite), 32'd0);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      idle("md_after");
      checkOutput("md_after.we_const", 32'(RegWrite), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
